mmio_uart_ctrl: RTL
===================

Name: mmio_uart_ctrl

Overview:
- Memory-mapped I/O slave for the CPU's memory/writeback stage; handles all accesses with addr[31:28] == 4'h8.
- Buffers UART RX bytes in a FIFO and holds or queues TX bytes.
- Owns the cycle counter and the retired-instruction counter.
- Read data is registered (1-cycle latency), matching dmem/bios timing so the writeback mux treats it like a memory read.

Parameters:
- RX_DEPTH, 8, RX FIFO entries; power of two, at least 2.
- TX_DEPTH, 8, TX FIFO entries; used only with MMIO_TX_FIFO_EN.

Ports:
- clk  input  1  CPU clock
- rst  input  1  synchronous active-high reset
- io_addr  input  32  byte address from the execute-stage ALU result
- io_wdata  input  32  store data; byte 0 is used for TX
- io_we  input  4  byte write mask; any bit set means a write
- io_re  input  1  load strobe (execute stage, I/O region)
- inst_retire  input  1  one pulse per retired non-bubble instruction
- io_rdata  output  32  registered read data
- uart_rx_data_out  input  8  UART RX byte
- uart_rx_data_out_valid  input  1  RX byte valid
- uart_rx_data_out_ready  output  1  equals !rx_full
- uart_tx_data_in  output  8  TX byte
- uart_tx_data_in_valid  output  1  TX byte valid
- uart_tx_data_in_ready  input  1  UART TX accepts

Behaviour:
- Address map (decode io_addr[7:0]; only io_addr[31:28] == 4'h8 is accepted, all else ignored):
  - 0x00 control, read: bit0 tx_ready, bit1 rx_nonempty, bit2 tx_drop (sticky); other bits 0.
  - 0x04 RX data, read: {24'b0, byte}; pops the FIFO.
  - 0x08 TX data, write: pushes io_wdata[7:0].
  - 0x10 cycle counter, read.
  - 0x14 instruction counter, read.
  - 0x18 counter reset, write any value.
- Reset: io_rdata=0, both FIFOs empty, uart_tx_data_in_valid=0, uart_tx_data_in=0, both counters=0, tx_drop=0. uart_rx_data_out_ready=1 on the first cycle after reset.
- Reads:
  - io_rdata is updated on the clock edge after io_re is sampled and holds until the next io_re.
  - Reads of unmapped offsets return 0.
  - A control read returns the pre-edge state and clears tx_drop. If a drop occurs in that same cycle, tx_drop stays set.
- RX path:
  - Push when valid && ready.
  - A read at 0x04 with FIFO non-empty returns the head and pops it in the same edge.
  - A read at 0x04 with FIFO empty returns 0 and does not pop.
  - Simultaneous push and pop: occupancy is unchanged. This is legal only when not full; when full, ready is already 0.
  - A push into an empty FIFO is not visible to a pop in the same cycle.
  - Pointers wrap modulo RX_DEPTH. Occupancy uses a log2(RX_DEPTH)+1-bit count.
- TX path (default): single holding register.
  - tx_ready = !uart_tx_data_in_valid.
  - A TX write when tx_ready loads the byte and sets valid on the next edge.
  - A TX write when not ready is dropped and sets tx_drop.
  - valid clears on the edge where valid && uart_tx_data_in_ready.
  - Handshake and a new write in the same cycle: the write is dropped, because tx_ready is evaluated pre-edge.
- Counters:
  - The cycle counter increments every non-reset cycle.
  - The instruction counter increments on inst_retire.
  - Both wrap 0xFFFF_FFFF -> 0.
  - A write to 0x18 makes both counters 0 after the edge; clear beats a simultaneous increment.
- Simultaneous io_re and io_we: the write takes effect and the read returns pre-edge values.
- Reset mid-operation: all state is discarded, including in-flight FIFO bytes and a pending TX byte.

Optional Feature:
- Macro: MMIO_TX_FIFO_EN.
- Defined: TX uses a TX_DEPTH FIFO.
  - tx_ready = !tx_full.
  - uart_tx_data_in and uart_tx_data_in_valid are driven from the FIFO head; valid = !tx_empty.
  - Pop on handshake. Push and pop in the same cycle are allowed.
  - A write when full is dropped and sets tx_drop.
- Undefined: single holding register as above.

Decomposition:
- Package mmio_pkg holds the MMIO_REGION nibble (4'h8), the offset constants (CTRL 0x00, RX 0x04, TX 0x08, CYC 0x10, INST 0x14, CRST 0x18) and the control bit indices.
- Sub-module io_fifo (params WIDTH, DEPTH; ports push/pop/din/dout/full/empty).
  - Instantiated once for RX, and a second time for TX under the macro.
  - dout is combinational from head.

Test Plan:
- Reset, then read 0x8000_0000 -> io_rdata 0x0000_0001 one cycle later. Read 0x8000_0010 after 10 idle cycles -> about 10, exact value checked against the bench cycle count.
- Push RX bytes 0x41 and 0x42, read 0x04 three times -> 0x41, 0x42, 0x00. rx_nonempty goes 1->1->0.
- Push 8 RX bytes -> ready=0; a 9th valid byte is not accepted. One pop -> ready=1, and the 9th byte is accepted and read last.
- Default build: write 0x55 to TX, then write 0x66 while uart_tx_data_in_ready=0 -> 0x66 dropped. Control read -> 0x4; a second control read -> 0x0.
- MMIO_TX_FIFO_EN: write 3 bytes with ready low, then raise ready -> bytes emitted in order 0x11, 0x22, 0x33.
- Pulse inst_retire 5 times, then write 0x18 while inst_retire=1 -> 0x14 reads 0. Preload the counter to 0xFFFF_FFFF via force, one retire -> reads 0.

Source files
------------

// File: rtl/mmio_uart_ctrl_pkg.sv
// mmio_pkg: shared constants for the MMIO UART/counter slave.
//   MMIO_REGION  - io_addr[31:28] value claimed by this slave
//   mmio_off_e   - io_addr[7:0] register offsets
//   CTRL_*       - bit positions in the control/status register
package mmio_pkg;

  localparam logic [3:0] MMIO_REGION = 4'h8;

  typedef enum logic [7:0] {
    OFF_CTRL = 8'h00,
    OFF_RX   = 8'h04,
    OFF_TX   = 8'h08,
    OFF_CYC  = 8'h10,
    OFF_INST = 8'h14,
    OFF_CRST = 8'h18
  } mmio_off_e;

  localparam int unsigned CTRL_TX_READY    = 0;
  localparam int unsigned CTRL_RX_NONEMPTY = 1;
  localparam int unsigned CTRL_TX_DROP     = 2;

endpackage

// File: rtl/mmio_uart_ctrl_io_fifo.sv
// io_fifo: synchronous FIFO, DEPTH a power of two >= 2.
//   clk, rst  - clock, synchronous active-high reset (empties FIFO)
//   push, din - write request/data; ignored when full
//   pop       - read request; ignored when empty
//   dout      - combinational head entry
//   full      - occupancy == DEPTH
//   empty     - occupancy == 0
module io_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rptr_q];
  // Gating on pre-edge flags: a push into an empty FIFO is not poppable
  // until the following cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: MMIO slave for io_addr[31:28] == 4'h8.
//   UART RX FIFO, UART TX holding register (or TX FIFO when the macro
//   MMIO_TX_FIFO_EN is defined), cycle and retired-instruction counters.
//   Read data is registered: io_rdata updates on the edge that samples
//   io_re and holds until the next accepted read.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   io_addr/io_wdata/io_we   - store address/data/byte mask
//   io_re                    - load strobe
//   inst_retire              - retired-instruction pulse
//   io_rdata                 - registered load data
//   uart_rx_data_out*        - RX byte stream in (valid/ready)
//   uart_tx_data_in*         - TX byte stream out (valid/ready)
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_we,
  input  logic        io_re,
  input  logic        inst_retire,
  output logic [31:0] io_rdata,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready
);

  logic        sel;
  logic [7:0]  off;
  logic        rd_en, wr_en;
  logic        ctrl_rd, rx_rd, tx_wr, crst_wr;
  logic        rx_full, rx_empty;
  logic [7:0]  rx_dout;
  logic        tx_ready;
  logic        tx_drop_q, tx_drop_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic        unused_bits;

  assign sel     = (io_addr[31:28] == MMIO_REGION);
  assign off     = io_addr[7:0];
  assign rd_en   = sel && io_re;
  assign wr_en   = sel && (|io_we);
  assign ctrl_rd = rd_en && (off == OFF_CTRL);
  assign rx_rd   = rd_en && (off == OFF_RX);
  assign tx_wr   = wr_en && (off == OFF_TX);
  assign crst_wr = wr_en && (off == OFF_CRST);

  assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

  // RX path
  assign uart_rx_data_out_ready = !rx_full;

  io_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_rx_data_out_valid && !rx_full),
    .pop   (rx_rd && !rx_empty),
    .din   (uart_rx_data_out),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // TX path
`ifdef MMIO_TX_FIFO_EN
  logic tx_full, tx_empty;

  assign tx_ready              = !tx_full;
  assign uart_tx_data_in_valid = !tx_empty;

  io_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr),
    .pop   (uart_tx_data_in_ready && !tx_empty),
    .din   (io_wdata[7:0]),
    .dout  (uart_tx_data_in),
    .full  (tx_full),
    .empty (tx_empty)
  );
`else
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       unused_tx_depth;

  assign unused_tx_depth       = (TX_DEPTH != 0);
  assign tx_ready              = !tx_valid_q;
  assign uart_tx_data_in_valid = tx_valid_q;
  assign uart_tx_data_in       = tx_data_q;

  // tx_ready is the pre-edge view, so a write arriving in the handshake
  // cycle is dropped rather than loaded.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_valid_q && uart_tx_data_in_ready) begin
      tx_valid_d = 1'b0;
    end
    if (tx_wr && tx_ready) begin
      tx_valid_d = 1'b1;
      tx_data_d  = io_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end
`endif

  // Sticky drop flag: a drop in the same cycle as a control read wins
  // over the read-clear.
  always_comb begin
    tx_drop_d = tx_drop_q;
    if (ctrl_rd) begin
      tx_drop_d = 1'b0;
    end
    if (tx_wr && !tx_ready) begin
      tx_drop_d = 1'b1;
    end
  end

  always_comb begin
    cyc_cnt_d  = cyc_cnt_q + 32'd1;
    inst_cnt_d = inst_cnt_q + {31'b0, inst_retire};
    if (crst_wr) begin
      cyc_cnt_d  = '0;
      inst_cnt_d = '0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (off)
        OFF_CTRL: begin
          rdata_d[CTRL_TX_READY]    = tx_ready;
          rdata_d[CTRL_RX_NONEMPTY] = !rx_empty;
          rdata_d[CTRL_TX_DROP]     = tx_drop_q;
        end
        OFF_RX: begin
          if (!rx_empty) begin
            rdata_d[7:0] = rx_dout;
          end
        end
        OFF_CYC:  rdata_d = cyc_cnt_q;
        OFF_INST: rdata_d = inst_cnt_q;
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_drop_q  <= 1'b0;
      rdata_q    <= '0;
      cyc_cnt_q  <= '0;
      inst_cnt_q <= '0;
    end else begin
      tx_drop_q  <= tx_drop_d;
      rdata_q    <= rdata_d;
      cyc_cnt_q  <= cyc_cnt_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

  assign io_rdata = rdata_q;

endmodule
